// File: rtl/ndma_pkg.sv
// Shared types and widths for the NanoDMA read-side blocks.
//   read_state_t : burst read manager FSM states
//   OBI_AW/OBI_DW: default OBI address / data widths
package ndma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } read_state_t;

  localparam int OBI_AW = 32;
  localparam int OBI_DW = 32;

endpackage

// File: rtl/ndma_fifo.sv
// Synchronous first-word-fall-through FIFO for OBI read data.
//   clk/rst   : clock, synchronous active-high reset (empties the FIFO)
//   push/push_data : write side; push while full is only legal together with a pop
//   pop       : consumer takes the head word (ignored when empty)
//   pop_data  : head word, valid whenever 'valid' is high
//   valid     : FIFO not empty
//   count     : current occupancy (0..DEPTH)
module ndma_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, pop_ok, push_ok;

  // Pointers wrap at DEPTH explicitly so the index never leaves the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign valid    = (count != '0);
  assign pop_ok   = pop && valid;
  // A push into a full FIFO is honoured only when a pop frees the slot this cycle.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; overflow means the upstream credit logic is broken.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
    if (!rst) assert (!(push && full && !pop_ok));
  end

endmodule

// File: rtl/ndma_burst_read_mgr.sv
// OBI burst read manager for NanoDMA.
// Accepts a (start address, word count) command, issues sequential word reads
// on OBI with at most MAX_OUTST requests in flight, and streams the returned
// words out through a FWFT FIFO.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   cmd_valid/ready/addr/len: burst command handshake (len 0 is legal)
//   obi_req/gnt/addr/we/be  : OBI address phase (read-only, full byte enables)
//   obi_rvalid/rdata/err    : OBI response phase
//   rd_valid/ready/data     : read-data stream (FIFO head)
//   done_o                  : one-cycle pulse after the last response of a burst
//   err_o                   : sticky error for the current/last burst
module ndma_burst_read_mgr
  import ndma_pkg::*;
#(
  parameter int AW         = OBI_AW,
  parameter int DW         = OBI_DW,
  parameter int LEN_W      = 16,
  parameter int MAX_OUTST  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [AW-1:0]    cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             obi_req_o,
  input  logic             obi_gnt_i,
  output logic [AW-1:0]    obi_addr_o,
  output logic             obi_we_o,
  output logic [DW/8-1:0]  obi_be_o,
  input  logic             obi_rvalid_i,
  input  logic [DW-1:0]    obi_rdata_i,
  input  logic             obi_err_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [DW-1:0]    rd_data_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int OW  = $clog2(MAX_OUTST+1);
  localparam int FCW = $clog2(FIFO_DEPTH+1);
  localparam int SW  = $clog2(MAX_OUTST+FIFO_DEPTH+1);

  read_state_t      state;
  logic [AW-1:0]    addr;
  logic [LEN_W-1:0] remaining;
  logic [OW-1:0]    outst;
  logic [FCW-1:0]   fifo_count;
  logic             gnt_acc, rsp_acc, credit_ok;

  // Words in flight plus words already buffered must leave room for one more.
  assign credit_ok = (SW'(outst) + SW'(fifo_count)) < SW'(FIFO_DEPTH);

  // Request is a pure function of registered state. While it waits for a
  // grant nothing can revoke it: remaining is unchanged, and a response only
  // moves a credit from outst to the FIFO while a pop only frees one.
  assign obi_req_o   = (state == ISSUE) && (remaining != '0) &&
                       (outst < OW'(MAX_OUTST)) && credit_ok;
  assign obi_addr_o  = addr;
  assign obi_we_o    = 1'b0;
  assign obi_be_o    = '1;
  assign cmd_ready_o = (state == IDLE);

  assign gnt_acc = obi_req_o && obi_gnt_i;
  // Responses with nothing outstanding (e.g. after a mid-burst reset) are dropped.
  assign rsp_acc = obi_rvalid_i && (outst != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      outst     <= '0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;

      case ({gnt_acc, rsp_acc})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: outst <= outst;
      endcase

      if (rsp_acc && obi_err_i) err_o <= 1'b1;

      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            addr      <= cmd_addr_i;
            remaining <= cmd_len_i;
            err_o     <= 1'b0;
            if (cmd_len_i == '0) done_o <= 1'b1;
            else                 state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (gnt_acc) begin
            addr      <= addr + AW'(DW/8);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // No grants here, so the final response takes outst from 1 to 0.
          if (rsp_acc && (outst == OW'(1))) begin
            done_o <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ndma_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (rsp_acc),
    .push_data (obi_rdata_i),
    .pop       (rd_ready_i),
    .pop_data  (rd_data_o),
    .valid     (rd_valid_o),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ndma_burst_read_mgr.sv
// Scoreboard bench for ndma_burst_read_mgr: a randomized OBI slave, a stream
// consumer and a done/err monitor check the DUT against per-burst expectations
// (address sequence, memory contents, error flag) queued when a command issues.
module tb_ndma_burst_read_mgr;

  localparam int AW = 32, DW = 32, LEN_W = 16, MAX_OUTST = 2, FIFO_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             obi_req;
  logic             obi_gnt = 1'b0;
  logic [AW-1:0]    obi_addr;
  logic             obi_we;
  logic [DW/8-1:0]  obi_be;
  logic             rv_s = 1'b0, rv_force = 1'b0;
  logic             obi_rvalid;
  logic [DW-1:0]    obi_rdata = '0;
  logic             obi_err = 1'b0;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [DW-1:0]    rd_data;
  logic             done, err;

  assign obi_rvalid = rv_s | rv_force;
  always #5 clk = ~clk;

  ndma_burst_read_mgr #(
    .AW(AW), .DW(DW), .LEN_W(LEN_W), .MAX_OUTST(MAX_OUTST), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .obi_req_o(obi_req), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr), .obi_we_o(obi_we), .obi_be_o(obi_be),
    .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata), .obi_err_i(obi_err),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .done_o(done), .err_o(err)
  );

  typedef struct { logic [31:0] addr; logic err; } word_t;
  typedef struct { logic [31:0] data; logic err; int due; } rsp_t;

  word_t       grant_q[$];   // words the DUT must request, in order
  logic [31:0] data_q[$];    // words the stream must deliver, in order
  logic        err_q[$];     // expected err_o at each done pulse
  rsp_t        rsp_q[$];     // slave's pending responses

  int checks = 0, failures = 0;
  int cyc = 0, pops_at_edge = 0;
  int grant_cnt = 0, rsp_cnt = 0, pop_cnt = 0, last_due = 0;
  int gnt_pct = 100, dmax = 0, ready_pct = 100;
  bit slave_on = 1'b1, mon_on = 1'b1;
  bit hold_pend = 1'b0;
  logic [31:0] hold_addr = '0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  always @(posedge clk) begin
    cyc++;
    pops_at_edge = pop_cnt;
  end

  // OBI slave: random grants, in-order responses with random latency.
  always @(negedge clk) begin
    bit    g;
    word_t w;
    rsp_t  r;
    if (!slave_on) begin
      obi_gnt = 1'b0; rv_s = 1'b0; obi_err = 1'b1;
      rsp_q.delete(); grant_q.delete();
      grant_cnt = 0; rsp_cnt = 0; last_due = 0; hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("req_hold", obi_req, 1);
        chk("addr_hold", obi_addr, hold_addr);
      end
      g = ($urandom_range(99) < gnt_pct);
      if (obi_req === 1'b1 && g) begin
        chk("outst_limit", (grant_cnt - rsp_cnt) < MAX_OUTST, 1);
        chk("fifo_credit", (grant_cnt - pops_at_edge) < FIFO_DEPTH, 1);
        if (grant_q.size() == 0) fail("extra_req");
        else begin
          w = grant_q.pop_front();
          chk("obi_addr", obi_addr, w.addr);
          r.due = cyc + 1 + $urandom_range(dmax);
          if (r.due <= last_due) r.due = last_due + 1;
          last_due = r.due;
          r.data = mem_f(obi_addr);
          r.err  = w.err;
          rsp_q.push_back(r);
          grant_cnt++;
        end
      end
      hold_pend = (obi_req === 1'b1) && !g;
      hold_addr = obi_addr;
      obi_gnt   = g;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        r = rsp_q.pop_front();
        rv_s = 1'b1; obi_rdata = r.data; obi_err = r.err;
        rsp_cnt++;
      end else begin
        rv_s = 1'b0; obi_rdata = $urandom; obi_err = 1'($urandom_range(1));
      end
    end
  end

  // Stream consumer: random ready, compares every popped word.
  always @(negedge clk) begin
    if (!mon_on) begin
      rd_ready = 1'b0; data_q.delete(); pop_cnt = 0;
    end else begin
      rd_ready = ($urandom_range(99) < ready_pct);
      if (rd_valid === 1'b1 && rd_ready) begin
        if (data_q.size() == 0) fail("extra_data");
        else chk("rd_data", rd_data, data_q.pop_front());
        pop_cnt++;
      end
    end
  end

  // Done monitor: one pulse per burst, after all responses, with the burst's err.
  always @(negedge clk) begin
    if (!mon_on) err_q.delete();
    else if (done === 1'b1) begin
      if (err_q.size() == 0) fail("extra_done");
      else begin
        chk("done_err", err, err_q.pop_front());
        chk("done_after_rsp", grant_cnt - rsp_cnt, 0);
      end
    end
  end

  task automatic chk_reset();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_req", obi_req, 0);
    chk("rst_addr", obi_addr, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("we_be", {obi_we, obi_be}, 5'b01111);
  endtask

  task automatic send_cmd(input logic [31:0] a, input int len, input int err_idx);
    int t = 0;
    bit was_empty;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = LEN_W'(len);
    while (cmd_ready !== 1'b1 && t < 3000) begin
      @(negedge clk); t++;
    end
    if (t >= 3000) begin
      fail("cmd_accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    was_empty = (grant_cnt == pops_at_edge);
    for (int i = 0; i < len; i++) begin
      word_t w;
      w.addr = a + 32'(4 * i);
      w.err  = (i == err_idx);
      grant_q.push_back(w);
      data_q.push_back(mem_f(w.addr));
    end
    err_q.push_back(err_idx >= 0 && err_idx < len);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (len == 0) begin
      chk("len0_done", done, 1);
      chk("len0_noreq", obi_req, 0);
    end else if (was_empty) begin
      chk("req_latency", obi_req, 1);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((grant_q.size() != 0 || data_q.size() != 0 || err_q.size() != 0) && t < 3000) begin
      @(negedge clk); t++;
    end
    if (t >= 3000) fail("idle_timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;

    // straight burst, immediate responses
    gnt_pct = 100; dmax = 0; ready_pct = 100;
    send_cmd(32'h100, 4, -1);
    wait_idle();

    // grant stalls: request and address must hold
    gnt_pct = 25;
    send_cmd(32'h0, 3, -1);
    wait_idle();

    // slow responses: outstanding limit
    gnt_pct = 100; dmax = 5;
    send_cmd(32'h200, 6, -1);
    wait_idle();

    // consumer stalled: only FIFO_DEPTH words may be issued
    dmax = 0; ready_pct = 0;
    g0 = grant_cnt;
    send_cmd(32'h400, 8, -1);
    repeat (30) @(negedge clk);
    chk("bp_issued", grant_cnt - g0, FIFO_DEPTH);
    ready_pct = 100;
    wait_idle();

    // zero length and address wrap
    send_cmd(32'h40, 0, -1);
    send_cmd(32'hFFFF_FFFC, 2, -1);
    wait_idle();

    // error on 2nd of 3 words stays sticky, cleared by the next command
    send_cmd(32'h80, 3, 1);
    wait_idle();
    chk("err_sticky", err, 1);
    send_cmd(32'h90, 1, -1);
    chk("err_cleared", err, 0);
    wait_idle();

    // randomized bursts
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int len, e;
      gnt_pct   = $urandom_range(100, 30);
      dmax      = $urandom_range(4);
      ready_pct = $urandom_range(100, 20);
      len = $urandom_range(12);
      a   = $urandom & 32'hFFFF_FFFC;
      if (i % 8 == 3) a = 32'hFFFF_FFF0;
      e = ($urandom_range(3) == 0 && len > 0) ? $urandom_range(len - 1) : -1;
      send_cmd(a, len, e);
      if ($urandom_range(1) == 1) wait_idle();
    end
    gnt_pct = 100; ready_pct = 100;
    wait_idle();
    chk("queues_empty", grant_q.size() + data_q.size() + err_q.size(), 0);

    // reset mid-burst, then a late response must be dropped
    ready_pct = 0; dmax = 8;
    send_cmd(32'h1000, 6, -1);
    repeat (3) @(negedge clk);
    slave_on = 1'b0; mon_on = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    rv_force = 1'b1;
    @(negedge clk);
    rv_force = 1'b0;
    chk("late_rsp_dropped", rd_valid, 0);
    chk("late_rsp_no_err", err, 0);
    @(negedge clk);
    chk("late_rsp_dropped2", rd_valid, 0);
    chk("late_rsp_no_done", done, 0);
    slave_on = 1'b1; mon_on = 1'b1;
    gnt_pct = 100; dmax = 1; ready_pct = 100;
    repeat (2) @(negedge clk);
    send_cmd(32'h2000, 2, -1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
